nios_ii_rd_data_x: RTL and testbench
====================================

// Module: nios_ii_rd_data_x
// PURPOSE
//  Avalon-MM slave input PIO: reader-side counterpart of the write-only output PIOs on the NIOS II bus.
//  Synchronises an external WIDTH-bit input bus into clk and exposes it at address 0.
//  Latches selected input edges into a write-1-to-clear capture register.
//  Optionally raises a masked level interrupt to the CPU.
// PARAMETERS
//  WIDTH        16  input bus width, 1..32; readdata bits above WIDTH read 0
//  SYNC_STAGES  2   synchroniser depth on in_port, >=2
//  EDGE_TYPE    0   capture edge: 0 rising, 1 falling, 2 any
// PORTS
//  clk         in   1      system clock; sole clock domain
//  reset       in   1      synchronous, active-high reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe; valid with chipselect
//  writedata   in   32     write data
//  readdata    out  32     read data, combinational from address, 0 wait states
//  in_port     in   WIDTH  asynchronous external input bus
//  irq         out  1      level interrupt; port exists only with NIOS_RD_DATA_IRQ_EN
// BEHAVIOUR
//  - Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
//  - Register map:
//      0  DATA     RO  synchronised in_port; writes ignored
//      1  (none)   reads 0; writes ignored
//      2  IRQMASK  RW  bits [WIDTH-1:0]
//      3  EDGECAP  R/W1C  writing 1 to a bit clears it
//  - Synchroniser: SYNC_STAGES flops on in_port, then one delay flop prev.
//  - Edge detect:
//      rise = sync & ~prev
//      fall = ~sync & prev
//      any  = sync ^ prev
//  - Latency:
//      in_port change -> DATA readable SYNC_STAGES cycles later.
//      Matching EDGECAP bit set on the next edge (SYNC_STAGES+1).
//  - EDGECAP bit, per clock:
//      set if edge detected;
//      else cleared if wr & address==3 & writedata[i];
//      else hold.
//  - Simultaneous edge and clear on the same bit: set wins; the bit reads 1 afterwards.
//  - Sticky: repeated edges on a set bit have no additional effect; there is no overflow count.
//  - Reset (any cycle, including mid-transfer):
//      all sync stages, prev, EDGECAP, IRQMASK -> 0; readdata follows -> 0; irq -> 0.
//  - Reset artefact: an input held high through reset produces one rising edge after reset
//    deassertion (prev starts at 0). This is intended; software clears EDGECAP at init.
//  - No wait states; writes take effect the cycle after wr; reads reflect current registers.
// CONFIGURATION
//  NIOS_RD_DATA_IRQ_EN defined:
//    - IRQMASK implemented (reset 0).
//    - irq = |(EDGECAP & IRQMASK), driven from registers only; no combinational path from the bus.
//    - irq asserts in the same cycle the EDGECAP bit becomes visible.
//  NIOS_RD_DATA_IRQ_EN undefined:
//    - irq port absent; no IRQMASK storage.
//    - address 2 reads 0; writes to address 2 ignored.
//    - DATA and EDGECAP unchanged.
// TESTING
//  1. Reset, in_port=0x0000, then in_port=0xA5A5 -> address 0 reads 0x0000A5A5 exactly SYNC_STAGES
//     cycles later; address 1 reads 0.
//  2. EDGE_TYPE=0, in_port 0x0000->0x0003->0x0001 -> EDGECAP=0x0003.
//     Write 0x0001 to addr 3 -> 0x0002; write 0xFFFF -> 0x0000.
//  3. Same-cycle bit-0 rising edge and W1C write 0x0001 to addr 3 -> EDGECAP bit 0 reads 1 afterwards.
//  4. IRQ_EN: IRQMASK=0x0004, edge on bit 0 -> irq stays 0.
//     Edge on bit 2 -> irq=1 on the cycle EDGECAP[2] sets; W1C 0x0004 -> irq=0 next cycle.
//  5. Assert reset mid-operation with EDGECAP=0x00FF, IRQMASK=0xFFFF, irq=1
//     -> next cycle all reads 0 and irq=0; repeat with EDGE_TYPE=1 and 2 to check falling/any.
//  6. IRQ_EN undefined: write 0x1234 to addr 2 -> addr 2 reads 0; EDGECAP operates as in test 2.

Source files
------------

// File: rtl/nios_ii_rd_data_x.sv
// Input PIO: synchronised in_port at addr 0, W1C edge capture at addr 3, optional IRQMASK/irq (NIOS_RD_DATA_IRQ_EN).
// Latency: DATA visible SYNC_STAGES cycles after in_port changes, EDGECAP/irq one cycle after that.
// Backpressure: none; zero wait states, reads combinational and side-effect free.
module nios_ii_rd_data_x #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port
`ifdef NIOS_RD_DATA_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int LAST = SYNC_STAGES - 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic             wr;

    assign wr = chipselect & ~write_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[LAST];
        end
    end

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det =  sync_q[LAST] & ~prev_q;
            1:       edge_det = ~sync_q[LAST] &  prev_q;
            default: edge_det =  sync_q[LAST] ^  prev_q;
        endcase
    end

    assign cap_clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge overrides a same-cycle W1C so no event is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecap_q <= '0;
        end else begin
            edgecap_q <= edge_det | (edgecap_q & ~cap_clr);
        end
    end

`ifdef NIOS_RD_DATA_IRQ_EN
    logic [WIDTH-1:0] irqmask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
        end else if (wr && address == 2'd2) begin
            irqmask_q <= writedata[WIDTH-1:0];
        end
    end

    assign irq = |(edgecap_q & irqmask_q);
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[WIDTH-1:0] = sync_q[LAST];
`ifdef NIOS_RD_DATA_IRQ_EN
            2'd2: readdata[WIDTH-1:0] = irqmask_q;
`endif
            2'd3: readdata[WIDTH-1:0] = edgecap_q;
            default: readdata = '0;
        endcase
    end

    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = |writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_nios_ii_rd_data_x.sv
// Directed bench for nios_ii_rd_data_x: one instance per EDGE_TYPE (rise/fall/any) on a shared bus.
module tb_nios_ii_rd_data_x;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] rd_rise, rd_fall, rd_any;
`ifdef NIOS_RD_DATA_IRQ_EN
    logic        irq_rise, irq_fall, irq_any;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios_ii_rd_data_x #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise), .in_port(in_port)
`ifdef NIOS_RD_DATA_IRQ_EN
        , .irq(irq_rise)
`endif
    );

    nios_ii_rd_data_x #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_fall), .in_port(in_port)
`ifdef NIOS_RD_DATA_IRQ_EN
        , .irq(irq_fall)
`endif
    );

    nios_ii_rd_data_x #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any), .in_port(in_port)
`ifdef NIOS_RD_DATA_IRQ_EN
        , .irq(irq_any)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd3(input string tag, input logic [1:0] a,
                       input logic [31:0] e_rise, input logic [31:0] e_fall, input logic [31:0] e_any);
        address = a;
        #1;
        chk({tag, "/rise"}, rd_rise, e_rise);
        chk({tag, "/fall"}, rd_fall, e_fall);
        chk({tag, "/any"},  rd_any,  e_any);
    endtask

`ifdef NIOS_RD_DATA_IRQ_EN
    task automatic chk_irq(input string tag, input logic e_rise, input logic e_fall, input logic e_any);
        chk({tag, "/irq_rise"}, {31'd0, irq_rise}, {31'd0, e_rise});
        chk({tag, "/irq_fall"}, {31'd0, irq_fall}, {31'd0, e_fall});
        chk({tag, "/irq_any"},  {31'd0, irq_any},  {31'd0, e_any});
    endtask
`endif

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 16'h0000;
        settle(3);
        rd3("rst_data", 2'd0, 0, 0, 0);
        rd3("rst_cap",  2'd3, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Test 1: synchroniser latency
        in_port = 16'hA5A5;
        tick();
        rd3("t1_data_lat1", 2'd0, 0, 0, 0);
        tick();
        rd3("t1_data_lat2", 2'd0, 32'h0000A5A5, 32'h0000A5A5, 32'h0000A5A5);
        rd3("t1_addr1", 2'd1, 0, 0, 0);
        settle(3);
        rd3("t1_cap", 2'd3, 32'h0000A5A5, 0, 32'h0000A5A5);
        wr(2'd3, 32'hFFFF);
        rd3("t1_clr", 2'd3, 0, 0, 0);

        // Test 2: capture and W1C
        in_port = 16'h0000;
        settle(4);
        wr(2'd3, 32'hFFFF);
        in_port = 16'h0003;
        settle(4);
        in_port = 16'h0001;
        settle(4);
        rd3("t2_cap", 2'd3, 32'h3, 32'h2, 32'h3);
        wr(2'd3, 32'h0001);
        rd3("t2_w1c1", 2'd3, 32'h2, 32'h2, 32'h2);
        wr(2'd3, 32'hFFFF);
        rd3("t2_w1call", 2'd3, 0, 0, 0);
        wr(2'd0, 32'hFFFF);
        rd3("t2_data_ro", 2'd0, 32'h1, 32'h1, 32'h1);

        // Test 3: edge and clear on the same cycle
        in_port = 16'h0000;
        settle(4);
        wr(2'd3, 32'hFFFF);
        in_port = 16'h0001;
        settle(2);
        rd3("t3_pre", 2'd3, 0, 0, 0);
        wr(2'd3, 32'h0001);
        rd3("t3_setwins", 2'd3, 32'h1, 32'h0, 32'h1);

`ifdef NIOS_RD_DATA_IRQ_EN
        // Test 4: masked interrupt
        in_port = 16'h0000;
        settle(4);
        wr(2'd3, 32'hFFFF);
        wr(2'd2, 32'h0004);
        rd3("t4_mask", 2'd2, 32'h4, 32'h4, 32'h4);
        in_port = 16'h0001;
        settle(4);
        rd3("t4_cap0", 2'd3, 32'h1, 32'h0, 32'h1);
        chk_irq("t4_masked", 1'b0, 1'b0, 1'b0);
        in_port = 16'h0005;
        settle(2);
        chk_irq("t4_pre", 1'b0, 1'b0, 1'b0);
        tick();
        chk_irq("t4_set", 1'b1, 1'b0, 1'b1);
        rd3("t4_cap2", 2'd3, 32'h5, 32'h0, 32'h5);
        wr(2'd3, 32'h0004);
        chk_irq("t4_clr", 1'b0, 1'b0, 1'b0);
        rd3("t4_cap_after", 2'd3, 32'h1, 32'h0, 32'h1);
`else
        // Test 6: no IRQMASK storage
        wr(2'd2, 32'h1234);
        rd3("t6_addr2", 2'd2, 0, 0, 0);
`endif

        // Test 5: reset mid-operation
        in_port = 16'h0000;
        settle(4);
        wr(2'd3, 32'hFFFF);
        in_port = 16'h00FF;
        settle(4);
        in_port = 16'h0000;
        settle(4);
        in_port = 16'h00FF;
        settle(4);
        rd3("t5_cap_pre", 2'd3, 32'hFF, 32'hFF, 32'hFF);
        rd3("t5_data_pre", 2'd0, 32'hFF, 32'hFF, 32'hFF);
`ifdef NIOS_RD_DATA_IRQ_EN
        wr(2'd2, 32'hFFFF);
        chk_irq("t5_irq_pre", 1'b1, 1'b1, 1'b1);
`endif
        reset = 1'b1;
        tick();
        rd3("t5_rst_a0", 2'd0, 0, 0, 0);
        rd3("t5_rst_a1", 2'd1, 0, 0, 0);
        rd3("t5_rst_a2", 2'd2, 0, 0, 0);
        rd3("t5_rst_a3", 2'd3, 0, 0, 0);
`ifdef NIOS_RD_DATA_IRQ_EN
        chk_irq("t5_rst_irq", 1'b0, 1'b0, 1'b0);
`endif
        tick();
        reset = 1'b0;

        // Input held high through reset yields one rising edge afterwards
        settle(4);
        rd3("art_cap", 2'd3, 32'hFF, 32'h0, 32'hFF);
        rd3("art_data", 2'd0, 32'hFF, 32'hFF, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
